// File: rtl/tick_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tick_countdown_timer
//  Description : Programmable countdown timer. It decrements once per
//                one-cycle tick strobe, which normally comes from the PULSE
//                output of clock_divider_pulse. A count is loaded through a
//                valid/ready handshake. When the count reaches zero the block
//                raises a one-cycle expire strobe and a sticky done flag.
//                It serves as the time base for particle-filter resample and
//                update scheduling.
//
//  Config      : TICK_TIMER_PERIODIC_EN
//                  defined   - the periodic input selects auto-reload mode.
//                  undefined - there is no reload/mode storage. Every load
//                              runs one-shot, and clear has no effect in RUN.
//
//  Ports       : clk         in   system clock, rising edge
//                rst         in   asynchronous active-high reset
//                tick        in   decrement enable strobe
//                load_valid  in   load request
//                load_ready  out  load accepted this cycle (IDLE or DONE)
//                load_value  in   count to load, in ticks
//                periodic    in   auto-reload mode, sampled on accept
//                stop        in   abort a running count
//                clear       in   clear the done flag
//                count       out  remaining ticks
//                busy        out  high while counting (RUN)
//                expire      out  one-cycle strobe on terminal count
//                done        out  sticky expiry flag
//
//  Revision    : 1.0  initial release
// ============================================================================
module tick_countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             periodic,
    input  logic             stop,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expire,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic             r_busy;
    logic             r_expire;
    logic             r_done;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_expire_nxt;
    logic             w_accept;
    logic             w_load_nonzero;
    logic             w_mode;
    logic [WIDTH-1:0] w_reload;
    logic             w_clear_run;

    assign load_ready     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept       = load_valid && load_ready;
    assign w_load_nonzero = (load_value != '0);

`ifdef TICK_TIMER_PERIODIC_EN
    logic             r_mode;
    logic [WIDTH-1:0] r_reload;

    // The reload value and mode are captured only on an accepted non-zero load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode   <= 1'b0;
            r_reload <= '0;
        end else if (w_accept && w_load_nonzero) begin
            r_mode   <= periodic;
            r_reload <= load_value;
        end
    end

    assign w_mode      = r_mode;
    assign w_reload    = r_reload;
    assign w_clear_run = clear;
`else
    logic w_unused_periodic;

    assign w_unused_periodic = periodic;
    assign w_mode            = 1'b0;
    assign w_reload          = '0;
    assign w_clear_run       = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_done_nxt   = r_done;
        w_expire_nxt = 1'b0;
        case (r_state)
            S_RUN: begin
                if (stop) begin
                    // STOP takes priority over a same-cycle tick, so no expiry happens.
                    w_state_nxt = S_IDLE;
                    w_count_nxt = '0;
                end else begin
                    if (w_clear_run) begin
                        w_done_nxt = 1'b0;
                    end
                    if (tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            // Terminal count. Expiry overrides a same-cycle clear of done.
                            w_expire_nxt = 1'b1;
                            w_done_nxt   = 1'b1;
                            if (w_mode) begin
                                w_count_nxt = w_reload;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = S_DONE;
                            end
                        end
                    end
                end
            end
            S_IDLE, S_DONE: begin
                // A load takes priority over clear.
                if (w_accept) begin
                    if (w_load_nonzero) begin
                        w_count_nxt = load_value;
                        w_done_nxt  = 1'b0;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_count_nxt  = '0;
                        w_expire_nxt = 1'b1;
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end
                end else if (clear) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean idle.
                w_state_nxt = S_IDLE;
                w_count_nxt = '0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_busy   <= 1'b0;
            r_expire <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_busy   <= (w_state_nxt == S_RUN);
            r_expire <= w_expire_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign count  = r_count;
    assign busy   = r_busy;
    assign expire = r_expire;
    assign done   = r_done;

endmodule
`default_nettype wire
